// File: rtl/output_scheduler.sv
// output_scheduler: per-(port,priority) chain-id FIFOs feeding one SRAM read engine.
// Latency: IDLE grant to first out_valid is 4 cycles; a len-N packet holds the engine N+3 cycles.
// Backpressure: port_ready gates arbitration only; a granted packet streams with no stall.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq_*                     enqueue request {chain_id, len, port, priority}; enq_drop pulses on reject
//   rea, chain_id             one-cycle release strobe and chain id towards the allocator
//   start_read_address        allocator-returned start address, valid the cycle after rea
//   sram_rd_en/addr/data      SRAM read port, data returns one cycle after the enable
//   port_ready                per-port ready, sampled only when picking a packet
//   out_valid/data/port/sop/eop  output word stream
//   drop_cnt                  saturating count of enq_drop pulses (only with OSCHED_DROP_CNT_EN)
module output_scheduler #(
  parameter int PORTS = 16,
  parameter int PRIOS = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [8:0]       enq_chain_id,
  input  logic [7:0]       enq_len,
  input  logic [3:0]       enq_port,
  input  logic [2:0]       enq_priority,
  output logic             enq_drop,
  output logic             rea,
  output logic [8:0]       chain_id,
  input  logic [11:0]      start_read_address,
  output logic             sram_rd_en,
  output logic [11:0]      sram_rd_addr,
  input  logic [63:0]      sram_rd_data,
  input  logic [PORTS-1:0] port_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic [3:0]       out_port,
  output logic             out_sop,
  output logic             out_eop
`ifdef OSCHED_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int NF = PORTS * PRIOS;
  localparam int FW = $clog2(NF);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ADDR, S_READ, S_DRAIN} state_t;

  state_t        state_q, state_d;

  // FIFO storage: entry = {chain_id[8:0], len[7:0]}
  logic [16:0]   mem_q    [NF][DEPTH];
  logic [AW-1:0] wr_ptr_q [NF];
  logic [AW-1:0] wr_ptr_d [NF];
  logic [AW-1:0] rd_ptr_q [NF];
  logic [AW-1:0] rd_ptr_d [NF];
  logic [CW-1:0] cnt_q    [NF];
  logic [CW-1:0] cnt_d    [NF];

  logic [3:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]    port_q, port_d;
  logic [7:0]    len_q, len_d;
  logic [8:0]    chain_id_q, chain_id_d;
  logic          rea_q, rea_d;
  logic [11:0]   addr_q, addr_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          first_q, first_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          enq_drop_q, enq_drop_d;

  logic [PORTS-1:0] eligible;
  logic             grant_vld;
  logic [3:0]       grant_port;
  logic [2:0]       grant_prio;
  logic [FW-1:0]    grant_idx;
  logic [FW-1:0]    enq_idx;
  logic [16:0]      head;
  logic             deq;
  logic             enq_ok;

  // A port is eligible when it is ready and any of its priority FIFOs holds a packet.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int r = 0; r < PRIOS; r++) begin
        if (cnt_q[FW'(p * PRIOS + r)] != '0) eligible[p] = port_ready[p];
      end
    end
  end

  always_comb begin
    grant_vld  = 1'b0;
    grant_port = '0;
    // Walk from the far end back towards rr_ptr so the surviving hit is the
    // first eligible port at or after rr_ptr.
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (eligible[4'((int'(rr_ptr_q) + i) % PORTS)]) begin
        grant_vld  = 1'b1;
        grant_port = 4'((int'(rr_ptr_q) + i) % PORTS);
      end
    end
    // Highest non-empty priority of the winner; higher r overrides lower.
    grant_prio = '0;
    for (int r = 0; r < PRIOS; r++) begin
      if (cnt_q[FW'(int'(grant_port) * PRIOS + r)] != '0) grant_prio = 3'(r);
    end
    grant_idx = FW'(int'(grant_port) * PRIOS + int'(grant_prio));
    head      = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  // Packet engine
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    port_d     = port_q;
    len_d      = len_q;
    chain_id_d = chain_id_q;
    rea_d      = 1'b0;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    first_d    = first_q;
    deq        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          deq        = 1'b1;
          port_d     = grant_port;
          chain_id_d = head[16:8];
          len_d      = head[7:0];
          rea_d      = 1'b1;
          rr_ptr_d   = 4'((int'(grant_port) + 1) % PORTS);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ADDR;
      S_ADDR: begin
        addr_d  = start_read_address;
        wcnt_d  = len_q;
        first_d = 1'b1;
        state_d = S_READ;
      end
      S_READ: begin
        addr_d  = addr_q + 12'd1;
        wcnt_d  = wcnt_q - 8'd1;
        first_d = 1'b0;
        if (wcnt_q == 8'd1) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Word flags travel one cycle alongside the SRAM return.
    out_valid_d = (state_q == S_READ);
    out_sop_d   = (state_q == S_READ) && first_q;
    out_eop_d   = (state_q == S_READ) && (wcnt_q == 8'd1);
  end

  // FIFO pointer and count update
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      wr_ptr_d[f] = wr_ptr_q[f];
      rd_ptr_d[f] = rd_ptr_q[f];
      cnt_d[f]    = cnt_q[f];
    end
    enq_idx = FW'(int'(enq_port) * PRIOS + int'(enq_priority));
    // A pop from the same FIFO this cycle frees the slot a full FIFO needs.
    enq_ok = enq_valid && (enq_len != 8'd0) &&
             ((cnt_q[enq_idx] != CW'(DEPTH)) || (deq && (grant_idx == enq_idx)));
    enq_drop_d = enq_valid && !enq_ok;
    if (deq) begin
      rd_ptr_d[grant_idx] = rd_ptr_q[grant_idx] + 1'b1;
      cnt_d[grant_idx]    = cnt_q[grant_idx] - 1'b1;
    end
    if (enq_ok) begin
      wr_ptr_d[enq_idx] = wr_ptr_q[enq_idx] + 1'b1;
      cnt_d[enq_idx]    = cnt_d[enq_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      port_q      <= '0;
      len_q       <= '0;
      chain_id_q  <= '0;
      rea_q       <= 1'b0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      enq_drop_q  <= 1'b0;
      for (int f = 0; f < NF; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        cnt_q[f]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      port_q      <= port_d;
      len_q       <= len_d;
      chain_id_q  <= chain_id_d;
      rea_q       <= rea_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      enq_drop_q  <= enq_drop_d;
      for (int f = 0; f < NF; f++) begin
        wr_ptr_q[f] <= wr_ptr_d[f];
        rd_ptr_q[f] <= rd_ptr_d[f];
        cnt_q[f]    <= cnt_d[f];
      end
    end
  end

  // Entry storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[enq_idx][wr_ptr_q[enq_idx]] <= {enq_chain_id, enq_len};
  end

  assign enq_drop     = enq_drop_q;
  assign rea          = rea_q;
  assign chain_id     = chain_id_q;
  assign sram_rd_en   = (state_q == S_READ);
  assign sram_rd_addr = addr_q;
  assign out_valid    = out_valid_q;
  // Gated so the bus reads zero whenever no word is being presented.
  assign out_data     = out_valid_q ? sram_rd_data : 64'd0;
  assign out_port     = port_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;

`ifdef OSCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (enq_drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_output_scheduler.sv
// Bench for output_scheduler: vector table, directed corner sequences and
// randomized batches compared against a queue-based scheduling model.
module tb_output_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enq_valid;
  logic [8:0]  enq_chain_id;
  logic [7:0]  enq_len;
  logic [3:0]  enq_port;
  logic [2:0]  enq_priority;
  logic        enq_drop;
  logic        rea;
  logic [8:0]  chain_id;
  logic [11:0] start_read_address;
  logic        sram_rd_en;
  logic [11:0] sram_rd_addr;
  logic [63:0] sram_rd_data;
  logic [15:0] port_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [3:0]  out_port;
  logic        out_sop;
  logic        out_eop;
`ifdef OSCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  output_scheduler dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_chain_id(enq_chain_id), .enq_len(enq_len),
    .enq_port(enq_port), .enq_priority(enq_priority), .enq_drop(enq_drop),
    .rea(rea), .chain_id(chain_id), .start_read_address(start_read_address),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .port_ready(port_ready), .out_valid(out_valid), .out_data(out_data),
    .out_port(out_port), .out_sop(out_sop), .out_eop(out_eop)
`ifdef OSCHED_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [63:0] sram_word(input logic [11:0] a);
    return {16'hD00D, 4'h0, a, ~{20'h0, a}};
  endfunction

  // SRAM and allocator models
  logic [11:0] addr_of [512];
  always @(posedge clk) sram_rd_data <= sram_word(sram_rd_addr);
  always @(posedge clk) if (rea) start_read_address <= addr_of[chain_id];
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  typedef struct { int cyc; logic [3:0] port; logic [63:0] data; logic sop; logic eop; } word_t;
  typedef struct { int cyc; logic [8:0] id; } rea_t;
  word_t       obs_w[$];
  rea_t        obs_r[$];
  logic [11:0] obs_a[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid)  obs_w.push_back('{cyc, out_port, out_data, out_sop, out_eop});
      if (rea)        obs_r.push_back('{cyc, chain_id});
      if (sram_rd_en) obs_a.push_back(sram_rd_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_w.delete();
    obs_r.delete();
    obs_a.delete();
  endtask

  task automatic enq(input logic [3:0] p, input logic [2:0] pr, input logic [8:0] id,
                     input logic [7:0] len, output logic drop);
    enq_valid = 1'b1; enq_port = p; enq_priority = pr; enq_chain_id = id; enq_len = len;
    step(1);
    enq_valid = 1'b0;
    drop = enq_drop;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int t = 0;
    while (obs_w.size() < n && t < budget) begin
      step(1);
      t++;
    end
    chk({name, " words arrived"}, 64'(obs_w.size() >= n), 64'd1);
    step(3);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " rea"}, 64'(rea), 64'd0);
    chk({tag, " sram_rd_en"}, 64'(sram_rd_en), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " sop/eop"}, 64'({out_sop, out_eop}), 64'd0);
    chk({tag, " chain_id"}, 64'(chain_id), 64'd0);
    chk({tag, " sram_rd_addr"}, 64'(sram_rd_addr), 64'd0);
    chk({tag, " out_data"}, out_data, 64'd0);
    chk({tag, " out_port"}, 64'(out_port), 64'd0);
    chk({tag, " enq_drop"}, 64'(enq_drop), 64'd0);
  endtask

  // Reference model: one queue per (port, priority), strict priority inside a
  // port, round-robin pointer across ports.
  typedef struct { logic [8:0] id; logic [7:0] len; } ent_t;
  typedef struct { logic [3:0] port; logic [63:0] data; logic sop; logic eop; } ew_t;
  ent_t        mq [128][$];
  ew_t         exp_w[$];
  logic [8:0]  exp_ids[$];
  int          mrr;

  function automatic bit port_has(input int p);
    for (int r = 0; r < 8; r++) if (mq[p * 8 + r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct { logic [3:0] port; logic [2:0] prio; logic [8:0] id; logic [7:0] len; logic exp_drop; } vec_t;
  vec_t vt [18];

  logic        d;
  int          c0, t, nenq, ridx, win, pp;
  logic [3:0]  rp;
  logic [2:0]  rpr;
  logic [8:0]  rid;
  logic [7:0]  rlen;
  logic        edrop;
  logic [15:0] mask;
  ent_t        e;
  logic [11:0] a;

  initial begin
    // FIFO-full vector table: 16 accepted, the 17th and a zero-length request dropped
    for (int i = 0; i < 16; i++) vt[i] = '{4'd1, 3'd0, 9'(100 + i), 8'd1, 1'b0};
    vt[16] = '{4'd1, 3'd0, 9'd116, 8'd1, 1'b1};
    vt[17] = '{4'd4, 3'd2, 9'd117, 8'd0, 1'b1};

    for (int i = 0; i < 512; i++) addr_of[i] = 12'(i * 16);
    rst = 1'b1; enq_valid = 1'b0; enq_chain_id = '0; enq_len = '0; enq_port = '0;
    enq_priority = '0; port_ready = '0;
    step(3);
    chk_idle_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single packet: id 5, len 3, port 2, prio 4 at address 0x100
    addr_of[5] = 12'h100;
    port_ready = 16'hFFFF;
    clear_obs();
    c0 = cyc;
    enq(4'd2, 3'd4, 9'd5, 8'd3, d);
    chk("single drop", 64'(d), 64'd0);
    wait_words(3, 40, "single");
    chk("single rea count", 64'(obs_r.size()), 64'd1);
    chk("single chain_id", 64'(obs_r[0].id), 64'd5);
    chk("single rea latency", 64'(obs_r[0].cyc - c0), 64'd2);
    chk("single first word latency", 64'(obs_w[0].cyc - c0), 64'd5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("single addr%0d", k), 64'(obs_a[k]), 64'(12'h100 + 12'(k)));
      chk($sformatf("single data%0d", k), obs_w[k].data, sram_word(12'h100 + 12'(k)));
      chk($sformatf("single port/sop/eop%0d", k), 64'({obs_w[k].port, obs_w[k].sop, obs_w[k].eop}),
          64'({4'd2, k == 0, k == 2}));
    end

    // Strict priority within port 0
    port_ready = '0;
    enq(4'd0, 3'd1, 9'd10, 8'd2, d);
    enq(4'd0, 3'd6, 9'd11, 8'd2, d);
    clear_obs();
    port_ready = 16'h0001;
    wait_words(4, 60, "prio");
    chk("prio first id", 64'(obs_r[0].id), 64'd11);
    chk("prio second id", 64'(obs_r[1].id), 64'd10);

    // Round-robin: serve port 3 to move the pointer to 4, then race ports 3 and 9
    port_ready = 16'hFFFF;
    clear_obs();
    enq(4'd3, 3'd0, 9'd30, 8'd1, d);
    wait_words(1, 40, "rr setup");
    port_ready = '0;
    enq(4'd3, 3'd0, 9'd20, 8'd1, d);
    enq(4'd9, 3'd0, 9'd21, 8'd1, d);
    clear_obs();
    port_ready = 16'hFFFF;
    wait_words(2, 60, "rr");
    chk("rr first id", 64'(obs_r[0].id), 64'd21);
    chk("rr second id", 64'(obs_r[1].id), 64'd20);
    chk("rr first word port/sop/eop", 64'({obs_w[0].port, obs_w[0].sop, obs_w[0].eop}), 64'({4'd9, 2'b11}));
    chk("rr second word port", 64'(obs_w[1].port), 64'd3);

    // FIFO full and zero-length drops
    port_ready = '0;
    for (int i = 0; i < 18; i++) begin
      enq(vt[i].port, vt[i].prio, vt[i].id, vt[i].len, d);
      chk($sformatf("table drop vec%0d", i), 64'(d), 64'(vt[i].exp_drop));
    end
    step(1);
`ifdef OSCHED_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    clear_obs();
    port_ready = 16'h0002;
    wait_words(16, 400, "full drain");
    port_ready = 16'hFFFF;
    step(20);
    chk("full drain rea count", 64'(obs_r.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("full drain id%0d", i), 64'(obs_r[i].id), 64'(100 + i));

    // Address wrap, then a len-1 packet
    addr_of[40] = 12'hFFE;
    clear_obs();
    enq(4'd7, 3'd3, 9'd40, 8'd3, d);
    wait_words(3, 40, "wrap");
    chk("wrap addr0", 64'(obs_a[0]), 64'hFFE);
    chk("wrap addr1", 64'(obs_a[1]), 64'hFFF);
    chk("wrap addr2", 64'(obs_a[2]), 64'h000);
    chk("wrap data2", obs_w[2].data, sram_word(12'h000));
    clear_obs();
    enq(4'd8, 3'd0, 9'd41, 8'd1, d);
    wait_words(1, 40, "len1");
    step(5);
    chk("len1 word count", 64'(obs_w.size()), 64'd1);
    chk("len1 sop/eop", 64'({obs_w[0].sop, obs_w[0].eop}), 64'b11);

    // Reset in the middle of a len-8 read with another packet still queued
    addr_of[50] = 12'h200;
    port_ready = 16'h0020;
    clear_obs();
    enq(4'd5, 3'd0, 9'd50, 8'd8, d);
    enq(4'd6, 3'd0, 9'd51, 8'd2, d);
    t = 0;
    while (obs_a.size() < 3 && t < 40) begin
      step(1);
      t++;
    end
    chk("midreset reached READ", 64'(obs_a.size() >= 3), 64'd1);
    rst = 1'b1;
    step(1);
    chk_idle_outputs("midreset");
    rst = 1'b0;
    clear_obs();
    port_ready = 16'hFFFF;
    step(30);
    chk("midreset no rea", 64'(obs_r.size()), 64'd0);
    chk("midreset no words", 64'(obs_w.size()), 64'd0);

    // Randomized batches against the model
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    mrr = 0;
    for (int i = 0; i < 128; i++) mq[i].delete();
    for (int i = 0; i < 512; i++) addr_of[i] = 12'($urandom);
    for (int rnd = 0; rnd < 8; rnd++) begin
      port_ready = '0;
      nenq = $urandom_range(24, 8);
      for (int k = 0; k < nenq; k++) begin
        rp   = 4'($urandom_range(15, 0));
        rpr  = 3'($urandom_range(7, 0));
        rid  = 9'($urandom_range(511, 0));
        rlen = ($urandom_range(9, 0) == 0) ? 8'd0 : 8'($urandom_range(5, 1));
        ridx = int'(rp) * 8 + int'(rpr);
        edrop = (rlen == 8'd0) || (mq[ridx].size() >= 16);
        enq(rp, rpr, rid, rlen, d);
        chk($sformatf("rand drop r%0d k%0d", rnd, k), 64'(d), 64'(edrop));
        if (!edrop) mq[ridx].push_back('{rid, rlen});
      end
      mask = (rnd == 7) ? 16'hFFFF : 16'($urandom_range(65535, 1));
      exp_ids.delete();
      exp_w.delete();
      while (1) begin
        win = -1;
        for (int i = 0; i < 16; i++) begin
          pp = (mrr + i) % 16;
          if (mask[pp] && port_has(pp)) begin
            win = pp;
            break;
          end
        end
        if (win < 0) break;
        for (int r = 7; r >= 0; r--) begin
          if (mq[win * 8 + r].size() > 0) begin
            e = mq[win * 8 + r].pop_front();
            break;
          end
        end
        mrr = (win + 1) % 16;
        exp_ids.push_back(e.id);
        for (int w = 0; w < int'(e.len); w++) begin
          a = addr_of[e.id] + 12'(w);
          exp_w.push_back('{4'(win), sram_word(a), w == 0, w == int'(e.len) - 1});
        end
      end
      clear_obs();
      port_ready = mask;
      wait_words(exp_w.size(), 3000, $sformatf("rand r%0d", rnd));
      step(10);
      chk($sformatf("rand r%0d rea count", rnd), 64'(obs_r.size()), 64'(exp_ids.size()));
      chk($sformatf("rand r%0d word count", rnd), 64'(obs_w.size()), 64'(exp_w.size()));
      for (int k = 0; k < exp_ids.size(); k++)
        chk($sformatf("rand r%0d id%0d", rnd, k), 64'(obs_r[k].id), 64'(exp_ids[k]));
      for (int k = 0; k < exp_w.size(); k++) begin
        chk($sformatf("rand r%0d data%0d", rnd, k), obs_w[k].data, exp_w[k].data);
        chk($sformatf("rand r%0d port/sop/eop%0d", rnd, k),
            64'({obs_w[k].port, obs_w[k].sop, obs_w[k].eop}),
            64'({exp_w[k].port, exp_w[k].sop, exp_w[k].eop}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
